iram_banked: RTL and testbench

IRAM_BANKED -- requirements
Module: iram_banked

---
 rtl/iram_pkg.sv | 18 +
 rtl/iram_bank.sv | 30 +++
 rtl/iram_banked.sv | 121 ++++++++++++
 tb/tb_iram_banked.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Shared defaults and payload layout for the banked instruction RAM.
package iram_pkg;

  localparam int LANES_DEF   = 2;
  localparam int PACKS_DEF   = 16;
  localparam int RDPORTS_DEF = 2;
  localparam int PW_DEF      = 56;

  // Field view of a default-width payload; the RAM itself never looks inside.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  dst;
    logic [5:0]  src_a;
    logic [5:0]  src_b;
    logic [29:0] imm;
  } payload_t;

endpackage

// File: rtl/iram_bank.sv
// One lane of instruction storage: PACKS x PW, single write port, RDPORTS async reads.
module iram_bank
  import iram_pkg::*;
#(
  parameter int PACKS   = PACKS_DEF,
  parameter int PW      = PW_DEF,
  parameter int RDPORTS = RDPORTS_DEF,
  localparam int PKW    = $clog2(PACKS)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [PKW-1:0]         waddr_i,
  input  logic [PW-1:0]          wdata_i,
  input  logic [RDPORTS*PKW-1:0] raddr_i,
  output logic [RDPORTS*PW-1:0]  rdata_o
);

  logic [PW-1:0] mem_q [PACKS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar p = 0; p < RDPORTS; p++) begin : g_rd
    assign rdata_o[p*PW +: PW] = mem_q[raddr_i[p*PKW +: PKW]];
  end

endmodule

// File: rtl/iram_banked.sv
// Lane-banked instruction RAM with per-entry valid bits, write-through read bypass,
// pack-level free, global flush and a live entry counter.
module iram_banked
  import iram_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int PACKS   = PACKS_DEF,
  parameter int RDPORTS = RDPORTS_DEF,
  parameter int PW      = PW_DEF,
  localparam int PKW    = $clog2(PACKS),
  localparam int LNW    = $clog2(LANES),
  localparam int IW     = PKW + LNW,
  localparam int CW     = IW + 1
) (
  input  logic                   cpu_clk_i,
  input  logic                   cpu_rst_i,
  input  logic [LANES-1:0]       wr_en_i,
  input  logic [PKW-1:0]         wr_pack_i,
  input  logic [LANES*PW-1:0]    wr_data_i,
  input  logic                   free_en_i,
  input  logic [PKW-1:0]         free_pack_i,
  input  logic                   flush_i,
  input  logic [RDPORTS-1:0]     rd_en_i,
  input  logic [RDPORTS*IW-1:0]  rd_idx_i,
  output logic [RDPORTS-1:0]     rd_valid_o,
  output logic [RDPORTS-1:0]     rd_miss_o,
  output logic [RDPORTS*PW-1:0]  rd_data_o,
  output logic [CW-1:0]          count_o
);

  localparam int ENTRIES = PACKS * LANES;

  logic [ENTRIES-1:0]           valid_q, valid_d;
  logic [CW-1:0]                count_q, count_d;
  logic [RDPORTS-1:0]           rd_valid_q, rd_miss_q;
  logic [RDPORTS*PW-1:0]        rd_data_q;
  logic [RDPORTS-1:0]           hit_d;
  logic [RDPORTS*PW-1:0]        data_d;
  logic [RDPORTS*PKW-1:0]       raddr;
  logic [LANES*RDPORTS*PW-1:0]  bank_rdata;

  // Entry index is {pack, lane}, so it doubles as the flat valid-bit index.
  for (genvar p = 0; p < RDPORTS; p++) begin : g_raddr
    assign raddr[p*PKW +: PKW] = PKW'(rd_idx_i[p*IW +: IW] >> LNW);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_bank
    iram_bank #(
      .PACKS   (PACKS),
      .PW      (PW),
      .RDPORTS (RDPORTS)
    ) u_bank (
      .clk_i   (cpu_clk_i),
      .we_i    (wr_en_i[l]),
      .waddr_i (wr_pack_i),
      .wdata_i (wr_data_i[l*PW +: PW]),
      .raddr_i (raddr),
      .rdata_o (bank_rdata[l*RDPORTS*PW +: RDPORTS*PW])
    );
  end

  // Same-cycle write wins over stored state; free/flush only take effect next edge.
  always_comb begin
    hit_d  = '0;
    data_d = '0;
    for (int p = 0; p < RDPORTS; p++) begin
      for (int l = 0; l < LANES; l++) begin
        if ((rd_idx_i[p*IW +: IW] & IW'(LANES-1)) == IW'(l)) begin
          if (wr_en_i[l] && (wr_pack_i == raddr[p*PKW +: PKW])) begin
            hit_d[p]            = 1'b1;
            data_d[p*PW +: PW]  = wr_data_i[l*PW +: PW];
          end else if (valid_q[rd_idx_i[p*IW +: IW]]) begin
            hit_d[p]            = 1'b1;
            data_d[p*PW +: PW]  = bank_rdata[(l*RDPORTS+p)*PW +: PW];
          end
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < PACKS; k++) begin
      for (int l = 0; l < LANES; l++) begin
        if (free_en_i && (free_pack_i == PKW'(k))) valid_d[k*LANES+l] = 1'b0;
        if (wr_en_i[l] && (wr_pack_i == PKW'(k))) valid_d[k*LANES+l] = 1'b1;
      end
    end
    if (flush_i) valid_d = '0;
    count_d = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      count_d = count_d + CW'(valid_d[e]);
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      valid_q    <= '0;
      count_q    <= '0;
      rd_valid_q <= '0;
      rd_miss_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      rd_valid_q <= rd_en_i;
      for (int p = 0; p < RDPORTS; p++) begin
        if (rd_en_i[p]) begin
          rd_miss_q[p]          <= ~hit_d[p];
          rd_data_q[p*PW +: PW] <= data_d[p*PW +: PW];
        end
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_miss_o  = rd_miss_q;
  assign rd_data_o  = rd_data_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_iram_banked.sv
// Directed bench for iram_banked at default parameters (2 lanes, 16 packs, 2 ports, 56-bit payload).
module tb_iram_banked;

  logic         clk;
  logic         rst;
  logic [1:0]   wr_en;
  logic [3:0]   wr_pack;
  logic [111:0] wr_data;
  logic         free_en;
  logic [3:0]   free_pack;
  logic         flush;
  logic [1:0]   rd_en;
  logic [9:0]   rd_idx;
  logic [1:0]   rd_valid;
  logic [1:0]   rd_miss;
  logic [111:0] rd_data;
  logic [5:0]   count;

  int checks;
  int failures;

  localparam logic [55:0] PA = 56'hAAAA_AAAA_AAAA_AA;
  localparam logic [55:0] PB = 56'hBBBB_BBBB_BBBB_BB;

  iram_banked dut (
    .cpu_clk_i   (clk),
    .cpu_rst_i   (rst),
    .wr_en_i     (wr_en),
    .wr_pack_i   (wr_pack),
    .wr_data_i   (wr_data),
    .free_en_i   (free_en),
    .free_pack_i (free_pack),
    .flush_i     (flush),
    .rd_en_i     (rd_en),
    .rd_idx_i    (rd_idx),
    .rd_valid_o  (rd_valid),
    .rd_miss_o   (rd_miss),
    .rd_data_o   (rd_data),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; free_en = 1'b0; flush = 1'b0; rd_en = 2'b00;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; wr_pack = '0; wr_data = '0; free_pack = '0; rd_idx = '0;
    idle();
    // Reset must override a concurrent write and read.
    wr_en = 2'b11; wr_pack = 4'd1; rd_en = 2'b11;
    tick(); tick();
    rst = 1'b0; idle();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_miss", 64'(rd_miss), 64'd0);
    chk("rst_data", 64'(rd_data[55:0] | rd_data[111:56]), 64'd0);

    // Basic write then read of both lanes.
    wr_en = 2'b11; wr_pack = 4'd3; wr_data = {PB, PA};
    tick();
    chk("wr_count2", 64'(count), 64'd2);
    idle(); rd_en = 2'b11; rd_idx = {5'd7, 5'd6};
    tick();
    chk("rd_valid11", 64'(rd_valid), 64'd3);
    chk("rd_miss00", 64'(rd_miss), 64'd0);
    chk("rd_data_p0", 64'(rd_data[55:0]), 64'(PA));
    chk("rd_data_p1", 64'(rd_data[111:56]), 64'(PB));

    // Write-through bypass on port 0; port 1 idle must hold its response.
    idle(); rd_en = 2'b01; rd_idx = {5'd0, 5'd9};
    wr_en = 2'b10; wr_pack = 4'd4; wr_data = {56'h5, 56'hFF};
    tick();
    chk("byp_valid", 64'(rd_valid), 64'd1);
    chk("byp_miss", 64'(rd_miss[0]), 64'd0);
    chk("byp_data", 64'(rd_data[55:0]), 64'h5);
    chk("hold_p1_data", 64'(rd_data[111:56]), 64'(PB));
    chk("byp_count", 64'(count), 64'd3);

    // Unwritten neighbour misses with zero data; equal indices on both ports agree.
    idle(); rd_en = 2'b11; rd_idx = {5'd8, 5'd8};
    tick();
    chk("miss8_p0", 64'(rd_miss), 64'd3);
    chk("miss8_data", 64'(rd_data[55:0] | rd_data[111:56]), 64'd0);
    idle(); rd_en = 2'b01; rd_idx = {5'd8, 5'd9};
    tick();
    chk("stored9", 64'(rd_data[55:0]), 64'h5);
    chk("stored9_miss", 64'(rd_miss), 64'd2);

    // Fill every entry; data for entry e is 0x100+e.
    idle();
    for (int k = 0; k < 16; k++) begin
      wr_en = 2'b11; wr_pack = 4'(k);
      wr_data = {56'h100 + 56'(2*k+1), 56'h100 + 56'(2*k)};
      tick();
    end
    idle();
    chk("full_count", 64'(count), 64'd32);

    // Free pack 0 while reading it: read sees pre-free contents.
    free_en = 1'b1; free_pack = 4'd0; rd_en = 2'b11; rd_idx = {5'd31, 5'd0};
    tick();
    chk("free_count", 64'(count), 64'd30);
    chk("free_rd_hit", 64'(rd_miss), 64'd0);
    chk("free_rd_data", 64'(rd_data[55:0]), 64'h100);
    chk("rd31_data", 64'(rd_data[111:56]), 64'h11F);
    idle(); rd_en = 2'b11; rd_idx = {5'd1, 5'd0};
    tick();
    chk("freed_miss", 64'(rd_miss), 64'd3);
    chk("freed_data", 64'(rd_data[55:0] | rd_data[111:56]), 64'd0);

    // Flush beats a same-cycle write; concurrent read still hits old contents.
    idle(); wr_en = 2'b11; wr_pack = 4'd2; wr_data = {56'hBEEF, 56'hDEAD};
    flush = 1'b1; rd_en = 2'b01; rd_idx = {5'd0, 5'd20};
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_rd_data", 64'(rd_data[55:0]), 64'h114);
    chk("flush_rd_hit", 64'(rd_miss[0]), 64'd0);
    idle(); rd_en = 2'b01; rd_idx = {5'd0, 5'd4};
    tick();
    chk("flushed_miss", 64'(rd_miss[0]), 64'd1);
    chk("flushed_data", 64'(rd_data[55:0]), 64'd0);

    // Write lane 0 and free the same pack: lane 0 kept, lane 1 cleared.
    idle(); wr_en = 2'b11; wr_pack = 4'd5; wr_data = {56'h22, 56'h11};
    tick();
    chk("pack5_count", 64'(count), 64'd2);
    idle(); wr_en = 2'b01; wr_pack = 4'd5; wr_data = {56'h77, 56'hC0FFEE};
    free_en = 1'b1; free_pack = 4'd5;
    tick();
    chk("wf_count", 64'(count), 64'd1);
    idle(); rd_en = 2'b11; rd_idx = {5'd11, 5'd10};
    tick();
    chk("wf_miss", 64'(rd_miss), 64'd2);
    chk("wf_data10", 64'(rd_data[55:0]), 64'hC0FFEE);
    chk("wf_data11", 64'(rd_data[111:56]), 64'd0);

    // Reset during an outstanding read suppresses its response.
    idle(); rd_en = 2'b11; rd_idx = {5'd10, 5'd10};
    tick();
    chk("pre_rst_valid", 64'(rd_valid), 64'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_data", 64'(rd_data[55:0] | rd_data[111:56]), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    rst = 1'b0; rd_en = 2'b01; rd_idx = {5'd0, 5'd10};
    tick();
    chk("post_rst_miss", 64'(rd_miss[0]), 64'd1);
    chk("post_rst_data", 64'(rd_data[55:0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
